seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is lit (legal >= 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink phase (used only with SEG_BLINK_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  16  four 4-bit glyph codes; [15:12] leftmost digit, [3:0] rightmost.
REQ-006 SHALL have port load  input  1  when high, data_in is captured on that clock edge.
REQ-007 SHALL have port blink  input  4  per-digit blink mask, bit i for digit i (present only with SEG_BLINK_EN).
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port an  output  4  digit enables, active-low, an[i] = digit i.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when digit 3 finishes its slot.

Function
REQ-011 SHALL hold a 16-bit display register; load=1 writes data_in into it; load=0 holds it.
REQ-012 SHALL make a loaded value visible in seg from the next clock edge, including mid-slot; no tearing within one nibble.
REQ-013 SHALL decode glyphs: 0x0-0x9 decimal digits, 0xA 'L', 0xB 'd', 0xC 'r', 0xD 'A', 0xE 'E', 0xF blank (seg=7'h7F).
REQ-014 SHALL keep a slot counter counting 0..REFRESH_DIV-1, wrapping to 0.
REQ-015 SHALL keep a 2-bit digit index that advances 0->1->2->3->0 on each slot-counter wrap.
REQ-016 SHALL drive exactly one an bit low at a time outside reset; that bit is the current digit index.
REQ-017 SHALL drive seg from the register nibble selected by the digit index.
REQ-018 SHALL register seg and an, so both change on the same edge; no one-cycle mismatch between digit and glyph.
REQ-019 SHALL pulse frame_done for exactly one cycle, on the cycle the counter wraps with digit index 3.
REQ-020 SHALL give load priority over nothing else: load never resets the counter or the digit index.
REQ-021 SHALL, when load and a slot wrap occur in the same cycle, show the new data on the new digit.

Reset
REQ-022 SHALL, while reset=1, force: slot counter 0, digit index 0, display register 16'hFFFF, an=4'b1111, seg=7'h7F, frame_done=0, blink phase 0.
REQ-023 SHALL give reset priority over load; data_in is ignored during reset.
REQ-024 SHALL, on the first edge after reset deasserts, drive an=4'b1110 with the glyph for register[3:0].

Configuration
REQ-025 SHALL define SEG_BLINK_EN as the only feature macro.
REQ-026 SHALL, with SEG_BLINK_EN defined: count frames, toggle a blink phase every BLINK_FRAMES frame_done pulses, and force seg=7'h7F for digit i when phase=1 and blink[i]=1; an still scans.
REQ-027 SHALL, with SEG_BLINK_EN undefined: omit the blink port, frame counter and phase; behaviour is identical to SEG_BLINK_EN defined with blink=0.

Structure
REQ-028 SHALL put the glyph code constants (GLY_L, GLY_D, GLY_R, GLY_A, GLY_E, GLY_BLANK) and the 7-bit segment patterns in the shared display package used by the print-select logic.
REQ-029 SHALL use one sub-module, seg_glyph_decode: combinational 4-bit code to 7-bit active-low segments.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-030 SHALL cover reset then idle: after release, an cycles 1110,1101,1011,0111, 4 clocks each, all seg=7'h7F; frame_done pulses every 16 clocks.
REQ-031 SHALL cover a single load: load 16'h1A2F at any time -> digit0 blank, digit1 seg of '2', digit2 'L', digit3 '1'.
REQ-032 SHALL cover mid-slot load: load 16'h0000 then 16'h9999 two clocks apart during the digit-0 slot -> seg switches '0'->'9' on the edge after the second load; an unchanged.
REQ-033 SHALL cover reset mid-scan: reset asserted during the digit-2 slot -> next edge an=1111, seg=7'h7F, register reads back blank after release.
REQ-034 SHALL cover blink (SEG_BLINK_EN): data 16'h1234, blink=4'b0001 -> digit0 shows '4' for 2 frames and blank for 2 frames; digits 1-3 are never blanked.
REQ-035 SHALL cover load coinciding with a slot wrap: new data appears on the newly selected digit on that same edge.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared display package: glyph codes, active-low segment patterns and scan helpers.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.

package seg_scan_driver_pkg;

    // Non-decimal glyph codes
    localparam logic [3:0] GLY_L     = 4'hA;
    localparam logic [3:0] GLY_D     = 4'hB;
    localparam logic [3:0] GLY_R     = 4'hC;
    localparam logic [3:0] GLY_A     = 4'hD;
    localparam logic [3:0] GLY_E     = 4'hE;
    localparam logic [3:0] GLY_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] DIG_LAST  = 2'd3;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low enable pattern for one digit
    function automatic logic [3:0] an_for_digit(input logic [1:0] dig);
        return ~(4'b0001 << dig);
    endfunction

    // Digit 0 is the rightmost nibble
    function automatic logic [3:0] nibble_sel(input logic [15:0] word, input logic [1:0] dig);
        logic [3:0] nib;
        case (dig)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            default: nib = word[15:12];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: 4-bit glyph code to 7-bit active-low segment pattern.

module seg_glyph_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (code_i)
            4'h0:      seg_o = SEG_0;
            4'h1:      seg_o = SEG_1;
            4'h2:      seg_o = SEG_2;
            4'h3:      seg_o = SEG_3;
            4'h4:      seg_o = SEG_4;
            4'h5:      seg_o = SEG_5;
            4'h6:      seg_o = SEG_6;
            4'h7:      seg_o = SEG_7;
            4'h8:      seg_o = SEG_8;
            4'h9:      seg_o = SEG_9;
            GLY_L:     seg_o = SEG_L;
            GLY_D:     seg_o = SEG_D;
            GLY_R:     seg_o = SEG_R;
            GLY_A:     seg_o = SEG_A;
            GLY_E:     seg_o = SEG_E;
            GLY_BLANK: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with registered seg/an outputs.
// Optional per-digit blinking is enabled by defining SEG_BLINK_EN.

module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
`ifdef SEG_BLINK_EN
    input  logic [3:0]  blink,
`endif
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned     CntW    = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_frames
        $error("BLINK_FRAMES must be at least 1");
    end

    logic            run_q, run_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      dig_q, dig_d;
    logic [15:0]     disp_q, disp_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            fd_q, fd_d;
    logic            slot_wrap;
    logic            frame_end;
    logic            blank;
    logic [6:0]      dec_seg;

    // run_q holds the first slot after reset at count 0 so every slot is REFRESH_DIV cycles.
    always_comb begin
        run_d     = 1'b1;
        cnt_d     = cnt_q;
        dig_d     = dig_q;
        disp_d    = disp_q;
        slot_wrap = run_q && (cnt_q == CntLast);
        frame_end = slot_wrap && (dig_q == DIG_LAST);
        if (load) begin
            disp_d = data_in;
        end
        if (slot_wrap) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else if (run_q) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    seg_glyph_decode u_decode (
        .code_i (nibble_sel(disp_d, dig_d)),
        .seg_o  (dec_seg)
    );

`ifdef SEG_BLINK_EN
    localparam int unsigned     FrmW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);

    logic [FrmW-1:0] frm_q, frm_d;
    logic            phase_q, phase_d;

    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (frame_end) begin
            if (frm_q == FrmLast) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FrmW'(1);
            end
        end
        blank = phase_d && blink[dig_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Outputs are built from next-state so a load or a wrap shows up on the same edge.
    always_comb begin
        seg_d = blank ? SEG_BLANK : dec_seg;
        an_d  = an_for_digit(dig_d);
        fd_d  = (cnt_d == CntLast) && (dig_d == DIG_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            dig_q  <= '0;
            disp_q <= 16'hFFFF;
            seg_q  <= SEG_BLANK;
            an_q   <= AN_OFF;
            fd_q   <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            disp_q <= disp_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            fd_q   <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule
